// File: rtl/alu_pipe_if.sv
// alu_pipe_if: issue, result and interrupt signals of the pipelined ALU.
interface alu_pipe_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              alu_enable;
  logic              alu_enable_a;
  logic              alu_enable_b;
  logic [1:0]        alu_op_a;
  logic [1:0]        alu_op_b;
  logic [DATA_W-1:0] alu_in_a;
  logic [DATA_W-1:0] alu_in_b;
  logic              alu_irq_clr;
  logic [DATA_W-1:0] alu_out;
  logic              alu_out_valid;
  logic              alu_irq;
  logic [2:0]        alu_irq_cause;
  logic [CNT_W-1:0]  alu_irq_count;
  modport master (
    output alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b, alu_irq_clr,
    input  alu_out, alu_out_valid, alu_irq, alu_irq_cause, alu_irq_count
  );
  modport slave (
    input  alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b, alu_irq_clr,
    output alu_out, alu_out_valid, alu_irq, alu_irq_cause, alu_irq_count
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage logic/arithmetic ALU with result strobe and sticky counted interrupt.
module alu_pipe #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  logic              v1;
  logic [1:0]        mode1;
  logic [1:0]        op_a1;
  logic [1:0]        op_b1;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   dif;
  logic [DATA_W-1:0] res;
  logic [2:0]        cause;
  logic              ev;
  assign sum = {1'b0, a1} + {1'b0, b1};
  assign dif = {1'b0, a1} - {1'b0, b1};
  assign ev  = v1 && cause != 3'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      mode1 <= '0;
      op_a1 <= '0;
      op_b1 <= '0;
      a1    <= '0;
      b1    <= '0;
    end else begin
      v1 <= bus.alu_enable && (bus.alu_enable_a || bus.alu_enable_b);
      if (bus.alu_enable) begin
        mode1 <= {bus.alu_enable_a, bus.alu_enable_b};
        op_a1 <= bus.alu_op_a;
        op_b1 <= bus.alu_op_b;
        a1    <= bus.alu_in_a;
        b1    <= bus.alu_in_b;
      end
    end
  end
  always_comb begin
    res   = '0;
    cause = 3'd0;
    case (mode1)
      2'b10: begin
        res   = op_a1 == 2'd0 ? a1 & b1 : op_a1 == 2'd1 ? ~(a1 & b1) : op_a1 == 2'd2 ? a1 | b1 : a1 ^ b1;
        cause = (op_a1 == 2'd3 && &res) ? 3'd1 : (op_a1 == 2'd1 && res == '0) ? 3'd2 : 3'd0;
      end
      2'b01: begin
        res   = op_b1 == 2'd0 ? ~(a1 ^ b1) : op_b1 == 2'd1 ? a1 & b1 : op_b1 == 2'd2 ? ~(a1 | b1) : a1 | b1;
        cause = (op_b1 == 2'd0 && &res) ? 3'd3 : (op_b1 == 2'd2 && &res) ? 3'd4 : 3'd0;
      end
      default: begin
        res   = op_a1 == 2'd0 ? sum[DATA_W-1:0] : op_a1 == 2'd1 ? dif[DATA_W-1:0] :
                op_a1 == 2'd2 ? (sum[DATA_W] ? '1 : sum[DATA_W-1:0]) : '0;
        cause = op_a1 == 2'd0 ? (sum[DATA_W] ? 3'd5 : 3'd0) : op_a1 == 2'd1 ? (dif[DATA_W] ? 3'd5 : 3'd0) :
                op_a1 == 2'd2 ? (sum[DATA_W] ? 3'd6 : 3'd0) : 3'd7;
      end
    endcase
  end
  // An event in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_out       <= '0;
      bus.alu_out_valid <= 1'b0;
      bus.alu_irq       <= 1'b0;
      bus.alu_irq_cause <= 3'd0;
      bus.alu_irq_count <= '0;
    end else begin
      bus.alu_out_valid <= v1;
      if (v1) bus.alu_out <= res;
      if (ev) begin
        bus.alu_irq       <= 1'b1;
        bus.alu_irq_cause <= cause;
        bus.alu_irq_count <= bus.alu_irq_clr ? CNT_W'(1) :
                             &bus.alu_irq_count ? bus.alu_irq_count : bus.alu_irq_count + CNT_W'(1);
      end else if (bus.alu_irq_clr) begin
        bus.alu_irq       <= 1'b0;
        bus.alu_irq_cause <= 3'd0;
        bus.alu_irq_count <= '0;
      end
    end
  end
endmodule
